// File: rtl/fixed_div_seq.sv
// rtl/fixed_div_seq.sv - sequential unsigned fixed-point radix-2 restoring divider
// result = (numerator << FRAC_BITS) / denominator, one quotient bit per cycle, saturating.
module fixed_div_seq #(
    parameter int NUM_W     = 64,
    parameter int DEN_W     = 32,
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16,
    parameter int ROUND     = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [NUM_W-1:0] i_numerator,
    input  logic [DEN_W-1:0] i_denominator,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_result,
    output logic             o_div_by_zero,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam int DW    = NUM_W + FRAC_BITS;
    localparam int HI_W  = DW - OUT_W;
    localparam int CMP_W = (HI_W > DEN_W + 1) ? HI_W : DEN_W + 1;
    localparam int CNT_W = $clog2(OUT_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ITER,
        S_FINAL,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]    r_d;
    logic [DEN_W-1:0] r_den;
    logic [DEN_W-1:0] r_rem;
    logic [OUT_W-1:0] r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_result;
    logic             r_dbz;
    logic             r_ovf;

    logic [DW-1:0]    w_d_in;
    logic [CMP_W-1:0] w_hi_ext;
    logic [CMP_W-1:0] w_den_ext;
    logic             w_den_zero;
    logic             w_too_big;
    logic [DEN_W:0]   w_den1;
    logic [DEN_W:0]   w_trial;
    logic             w_ge;
    logic [DEN_W-1:0] w_diff;
    logic [DEN_W:0]   w_rem2;
    logic             w_rnd_up;
    logic             w_last;

    assign w_d_in     = DW'(i_numerator) << FRAC_BITS;
    assign w_hi_ext   = CMP_W'(r_d[DW-1:OUT_W]);
    assign w_den_ext  = CMP_W'(r_den);
    assign w_den_zero = (r_den == '0);
    assign w_too_big  = (w_hi_ext >= w_den_ext);

    // The stored remainder is always below the divisor, so it fits DEN_W bits;
    // only the shifted trial value needs the extra bit.
    assign w_den1   = {1'b0, r_den};
    assign w_trial  = {r_rem, r_d[OUT_W-1]};
    assign w_ge     = (w_trial >= w_den1);
    assign w_diff   = w_trial[DEN_W-1:0] - r_den;
    assign w_rem2   = {r_rem, 1'b0};
    assign w_rnd_up = (ROUND != 0) && (w_rem2 >= w_den1);
    assign w_last   = (r_cnt == CNT_W'(OUT_W - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_den_zero || w_too_big) begin
                    w_next = S_OUT;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_ITER: begin
                if (w_last) begin
                    w_next = S_FINAL;
                end
            end
            S_FINAL: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_d      <= '0;
            r_den    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_d   <= w_d_in;
                        r_den <= i_denominator;
                    end
                end
                S_CHECK: begin
                    if (w_den_zero) begin
                        r_result <= '1;
                        r_dbz    <= 1'b1;
                        r_ovf    <= 1'b0;
                    end else if (w_too_big) begin
                        r_result <= '1;
                        r_dbz    <= 1'b0;
                        r_ovf    <= 1'b1;
                    end else begin
                        r_rem  <= w_hi_ext[DEN_W-1:0];
                        r_quot <= '0;
                        r_cnt  <= '0;
                        r_dbz  <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_ITER: begin
                    r_d    <= r_d << 1;
                    r_rem  <= w_ge ? w_diff : w_trial[DEN_W-1:0];
                    r_quot <= (r_quot << 1) | OUT_W'(w_ge);
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_FINAL: begin
                    // Rounding up an all-ones quotient would wrap, so it saturates instead.
                    if (w_rnd_up && (&r_quot)) begin
                        r_result <= '1;
                        r_ovf    <= 1'b1;
                    end else if (w_rnd_up) begin
                        r_result <= r_quot + 1'b1;
                    end else begin
                        r_result <= r_quot;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_in_ready    = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_out_valid   = (r_state == S_OUT);
    assign o_result      = r_result;
    assign o_div_by_zero = r_dbz;
    assign o_overflow    = r_ovf;

endmodule

// File: doc/fixed_div_seq.md
Name: fixed_div_seq

Overview:
Parameterised sequential unsigned fixed-point divider. Computes result = (numerator << FRAC_BITS) / denominator, producing one quotient bit per cycle (radix-2 restoring). Detects divide-by-zero and saturates on overflow. Supports optional round-to-nearest. Sits between the value-accumulation path and downstream scaling logic, using a valid/ready handshake on both input and output.

Parameters:
NUM_W, 64, numerator width (bits)
DEN_W, 32, denominator width (bits)
OUT_W, 32, quotient width (bits); also the iteration count
FRAC_BITS, 16, left shift applied to numerator before division; legal range 0 <= FRAC_BITS < OUT_W
ROUND, 0, 0 = truncate (floor), 1 = round half up

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  operands present
in_ready  out  1  block can accept operands; high iff state == IDLE
numerator  in  NUM_W  unsigned dividend
denominator  in  DEN_W  unsigned divisor
out_valid  out  1  result and flags valid
out_ready  in  1  downstream accepts result
result  out  OUT_W  quotient, saturated
div_by_zero  out  1  denominator was 0
overflow  out  1  true quotient did not fit in OUT_W bits; result saturated
busy  out  1  state != IDLE

Behaviour:
- Reset: rstn low at a clk edge → state = IDLE, out_valid = 0, result = 0, div_by_zero = 0, overflow = 0, busy = 0, iteration counter = 0. Reset mid-operation abandons the operation; no result is emitted.
- Notation: D = numerator << FRAC_BITS, width NUM_W + FRAC_BITS.
- States: IDLE, CHECK, ITER, FINAL, OUT.
- IDLE: in_ready = 1. On in_valid, register the operands and go to CHECK (accept edge = edge 0). in_valid is ignored in every other state.
- CHECK (edge 1):
  - If denominator == 0: result = all ones, div_by_zero = 1, overflow = 0, go to OUT.
  - Else if (D >> OUT_W) >= denominator: result = all ones, overflow = 1, go to OUT.
  - Else: partial remainder R = D >> OUT_W (DEN_W+1 bits; R < denominator is guaranteed), counter = 0, go to ITER.
- ITER (edges 2 .. OUT_W+1), iteration i:
  - R = {R, D[OUT_W-1-i]}.
  - If R >= denominator: R = R − denominator, quotient bit = 1; else quotient bit = 0.
  - Quotient bits are produced MSB first.
  - After iteration OUT_W−1, go to FINAL.
- FINAL (edge OUT_W+2):
  - ROUND = 0: result = quotient.
  - ROUND = 1: if 2·R >= denominator, result = quotient + 1. If quotient was all ones, result stays all ones and overflow = 1.
  - Set out_valid = 1, go to OUT.
- Latency: normal path, out_valid first visible after edge OUT_W+2 (34 cycles at default parameters). Zero-denominator and overflow paths, out_valid after edge 1.
- OUT: result and flags held stable while out_valid = 1 and out_ready = 0. On the edge where out_valid && out_ready: out_valid = 0, state = IDLE. No same-cycle bypass to a new input: in_ready rises the cycle after the output handshake. Flags keep their values until the next CHECK overwrites them.
- Result is exact: floor(D / denominator), or the rounded value when ROUND = 1, for every non-saturating input. div_by_zero and overflow are never both 1.
- numerator = 0 with denominator != 0 → result 0, no flags, full latency.
- Width rules: all arithmetic is unsigned. The comparison and subtraction use DEN_W+1 bits so no carry is lost.

Test Plan:
- Default parameters: numerator = 6, denominator = 3 → result 0x00020000, flags 0, out_valid after exactly 34 cycles from the accept edge; in_ready = 0 throughout.
- numerator = 5, denominator = 0 → result 0xFFFFFFFF, div_by_zero = 1, overflow = 0, out_valid after edge 1. Same outcome for numerator = 0, denominator = 0.
- numerator = 0x10000, denominator = 1 → overflow = 1, result 0xFFFFFFFF. numerator = 0xFFFF, denominator = 1 → result 0xFFFF0000, overflow = 0.
- ROUND = 0: numerator = 2, denominator = 3 → 0x0000AAAA. ROUND = 1: same operands → 0x0000AAAB; numerator = 1, denominator = 3 → 0x00005555.
- Backpressure: out_ready held 0 for 10 cycles after out_valid → result and flags stable, in_ready = 0, a pulsed in_valid with new operands is ignored. Raise out_ready → next cycle in_ready = 1, and the next operands are accepted and computed correctly.
- Reset during iteration 10: rstn low for one edge → out_valid = 0, in_ready = 1, all outputs 0. No result for the aborted operation appears. A subsequent 6/3 returns 0x00020000.
